// File: rtl/axis_tx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_tx_rr_arbiter
//
// Merges PORT_NUM AXI-Stream FIFO outputs onto one AXI-Stream transmit channel.
// Arbitration is round-robin at packet granularity: the granted FIFO owns the
// output until its tlast beat has been accepted. The transmit side is driven
// from a single output register stage.
//
// Parameters
//   PORT_NUM        number of FIFO inputs, 2..8
//
// Ports
//   glb_clk         sole clock, rising edge
//   glb_areset_n    asynchronous active-low reset
//   s_axis_tvalid   [PORT_NUM]      per-FIFO beat valid
//   s_axis_tready   [PORT_NUM]      per-FIFO ready (only the granted bit may be 1)
//   s_axis_tdata    [PORT_NUM*32]   FIFO i at bits [32i+31:32i]
//   s_axis_tkeep    [PORT_NUM*4]    FIFO i at bits [4i+3:4i]
//   s_axis_tlast    [PORT_NUM]      per-FIFO end of packet
//   m_axis_tvalid   TX beat valid (registered)
//   m_axis_tready   TX ready
//   m_axis_tdata    [32] TX data (registered)
//   m_axis_tkeep    [4]  TX byte enables (registered)
//   m_axis_tlast    TX end of packet (registered)
//   grant_port      [8]  index of the owning FIFO, meaningful while busy=1
//   busy            high while a packet is being forwarded
// -----------------------------------------------------------------------------
module axis_tx_rr_arbiter #(
  parameter int PORT_NUM = 4
) (
  input  logic                    glb_clk,
  input  logic                    glb_areset_n,
  input  logic [PORT_NUM-1:0]     s_axis_tvalid,
  output logic [PORT_NUM-1:0]     s_axis_tready,
  input  logic [PORT_NUM*32-1:0]  s_axis_tdata,
  input  logic [PORT_NUM*4-1:0]   s_axis_tkeep,
  input  logic [PORT_NUM-1:0]     s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             m_axis_tdata,
  output logic [3:0]              m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [7:0]              grant_port,
  output logic                    busy
);

  // Index width covers the largest legal PORT_NUM (8), so every internal
  // index is exactly 3 bits and selects into 8-entry padded views.
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_NUM - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  // Next index after idx, wrapping to 0 after the last port.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx >= LAST_IDX) begin
      nxt = {IDX_W{1'b0}};
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

  // Round-robin search: first requester at or after ptr, wrapping upward.
  // Returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [7:0]       req,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end else begin
        found = found;
      end
      cand = wrap_inc(cand);
    end
    return {found, win};
  endfunction

  // State and output-stage flops.
  state_t           state_q,  state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q,  grant_d;
  logic             m_valid_q, m_valid_d;
  logic [31:0]      m_data_q,  m_data_d;
  logic [3:0]       m_keep_q,  m_keep_d;
  logic             m_last_q,  m_last_d;

  // Padded 8-entry views of the inputs so the 3-bit grant can index directly.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [31:0] data_arr [8];
  logic [3:0]  keep_arr [8];

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < PORT_NUM) begin : g_real
      assign valid_pad[g] = s_axis_tvalid[g];
      assign last_pad[g]  = s_axis_tlast[g];
      assign data_arr[g]  = s_axis_tdata[32*g +: 32];
      assign keep_arr[g]  = s_axis_tkeep[4*g +: 4];
    end else begin : g_zero
      assign valid_pad[g] = 1'b0;
      assign last_pad[g]  = 1'b0;
      assign data_arr[g]  = 32'h0000_0000;
      assign keep_arr[g]  = 4'h0;
    end
  end

  logic             pkt_s;
  logic             out_free_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic             beat_acc_s;
  logic [IDX_W:0]   pick_s;

  assign pkt_s       = (state_q == ST_PKT);
  // Output register can take a new beat when empty or being drained this cycle.
  assign out_free_s  = !m_valid_q || m_axis_tready;
  assign sel_valid_s = valid_pad[grant_q];
  assign sel_last_s  = last_pad[grant_q];
  assign beat_acc_s  = pkt_s && sel_valid_s && out_free_s;
  assign pick_s      = rr_pick(valid_pad, rr_ptr_q);

  // Only the granted FIFO sees ready; everything else is held off.
  for (genvar g = 0; g < PORT_NUM; g++) begin : g_ready
    assign s_axis_tready[g] = pkt_s && out_free_s && (grant_q == IDX_W'(g));
  end

  // Arbitration FSM: grant in IDLE, release on accepted tlast in PKT.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[IDX_W]) begin
          grant_d = pick_s[IDX_W-1:0];
          state_d = ST_PKT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PKT: begin
        if (beat_acc_s && sel_last_s) begin
          rr_ptr_d = wrap_inc(grant_q);
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_PKT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Output stage: load on accepted beat, drain when downstream takes it.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    if (beat_acc_s) begin
      m_valid_d = 1'b1;
      m_data_d  = data_arr[grant_q];
      m_keep_d  = keep_arr[grant_q];
      m_last_d  = sel_last_s;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State and output registers; reset truncates any packet in flight.
  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= {IDX_W{1'b0}};
      grant_q   <= {IDX_W{1'b0}};
      m_valid_q <= 1'b0;
      m_data_q  <= 32'h0000_0000;
      m_keep_q  <= 4'h0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign grant_port    = {{(8-IDX_W){1'b0}}, grant_q};
  assign busy          = pkt_s;

endmodule

// File: tb/tb_axis_tx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for axis_tx_rr_arbiter (PORT_NUM=4). Each FIFO is a small
// packet source: beat data = base[p] + 16*packet_count + beat_index, keep is
// 4'hF except 4'h7 on the tlast beat. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_axis_tx_rr_arbiter;
  localparam int PORT_NUM = 4;

  logic                   glb_clk = 1'b0;
  logic                   glb_areset_n;
  logic [PORT_NUM-1:0]    s_axis_tvalid;
  logic [PORT_NUM-1:0]    s_axis_tready;
  logic [PORT_NUM*32-1:0] s_axis_tdata;
  logic [PORT_NUM*4-1:0]  s_axis_tkeep;
  logic [PORT_NUM-1:0]    s_axis_tlast;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [31:0]            m_axis_tdata;
  logic [3:0]             m_axis_tkeep;
  logic                   m_axis_tlast;
  logic [7:0]             grant_port;
  logic                   busy;

  axis_tx_rr_arbiter #(.PORT_NUM(PORT_NUM)) dut (
    .glb_clk       (glb_clk),
    .glb_areset_n  (glb_areset_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .grant_port    (grant_port),
    .busy          (busy)
  );

  always #5 glb_clk = ~glb_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          npk  [4];
  int          plen [4];
  int          bidx [4];
  int          pcnt [4];
  logic [31:0] base [4];
  logic [3:0]  acc;

  logic [31:0] t2_data  [16] = '{32'h1020, 32'h1021, 32'h2010, 32'h2011,
                                 32'h00C0, 32'h00C1, 32'h3020, 32'h3021,
                                 32'h1030, 32'h1031, 32'h2020, 32'h2021,
                                 32'h00D0, 32'h00D1, 32'h3030, 32'h3031};
  int          t2_grant [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int p = 0; p < PORT_NUM; p++) begin
      logic lst;
      lst = (bidx[p] == plen[p] - 1);
      s_axis_tvalid[p]         = (npk[p] != 0);
      s_axis_tlast[p]          = lst;
      s_axis_tdata[32*p +: 32] = base[p] + 32'(pcnt[p] * 16 + bidx[p]);
      s_axis_tkeep[4*p +: 4]   = lst ? 4'h7 : 4'hF;
    end
  endtask

  task automatic src_send(input int p, input int n, input int l);
    npk[p]  = n;
    plen[p] = l;
    bidx[p] = 0;
    drive_src();
  endtask

  // One clock: record accepted beats before the edge, advance sources after.
  task automatic step();
    @(negedge glb_clk);
    acc = s_axis_tvalid & s_axis_tready;
    @(posedge glb_clk);
    #1;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (acc[p]) begin
        if (bidx[p] == plen[p] - 1) begin
          bidx[p] = 0;
          pcnt[p] = pcnt[p] + 1;
          npk[p]  = npk[p] - 1;
        end else begin
          bidx[p] = bidx[p] + 1;
        end
      end
    end
    drive_src();
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_mvalid"}, 32'(m_axis_tvalid), 32'h0);
    check_eq({tag, "_mdata"},  m_axis_tdata,       32'h0);
    check_eq({tag, "_mkeep"},  32'(m_axis_tkeep),  32'h0);
    check_eq({tag, "_mlast"},  32'(m_axis_tlast),  32'h0);
    check_eq({tag, "_busy"},   32'(busy),          32'h0);
    check_eq({tag, "_grant"},  32'(grant_port),    32'h0);
    check_eq({tag, "_sready"}, 32'(s_axis_tready), 32'h0);
  endtask

  initial begin
    base[0] = 32'h1000; base[1] = 32'h2000; base[2] = 32'h00A0; base[3] = 32'h3000;
    for (int p = 0; p < PORT_NUM; p++) begin
      npk[p] = 0; plen[p] = 1; bidx[p] = 0; pcnt[p] = 0;
    end
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
    m_axis_tready = 1'b1;
    glb_areset_n  = 1'b0;
    repeat (3) @(posedge glb_clk);
    #2;
    check_zero("rst");
    glb_areset_n = 1'b1;

    // FIFO 2, 3-beat packet A0..A2.
    src_send(2, 1, 3);
    step();
    check_eq("t1_busy",   32'(busy),          32'h1);
    check_eq("t1_grant",  32'(grant_port),    32'h2);
    check_eq("t1_sready", 32'(s_axis_tready), 32'h4);
    check_eq("t1_mvalid_lat1", 32'(m_axis_tvalid), 32'h0);
    step();
    check_eq("t1_mvalid_lat2", 32'(m_axis_tvalid), 32'h1);
    check_eq("t1_d0",    m_axis_tdata,        32'hA0);
    check_eq("t1_l0",    32'(m_axis_tlast),   32'h0);
    check_eq("t1_k0",    32'(m_axis_tkeep),   32'hF);
    step();
    check_eq("t1_d1",    m_axis_tdata,        32'hA1);
    check_eq("t1_l1",    32'(m_axis_tlast),   32'h0);
    check_eq("t1_grant_mid", 32'(grant_port), 32'h2);
    step();
    check_eq("t1_d2",    m_axis_tdata,        32'hA2);
    check_eq("t1_l2",    32'(m_axis_tlast),   32'h1);
    check_eq("t1_k2",    32'(m_axis_tkeep),   32'h7);
    check_eq("t1_idle",  32'(busy),           32'h0);
    step();
    check_eq("t1_drain", 32'(m_axis_tvalid),  32'h0);

    // Single-beat packets from FIFO 3 and FIFO 0; pointer sits at 3.
    src_send(0, 1, 1);
    src_send(3, 1, 1);
    step();
    check_eq("t5_grant3", 32'(grant_port),    32'h3);
    check_eq("t5_sready", 32'(s_axis_tready), 32'h8);
    step();
    check_eq("t5_d3",    m_axis_tdata,        32'h3000);
    check_eq("t5_l3",    32'(m_axis_tlast),   32'h1);
    check_eq("t5_idle",  32'(busy),           32'h0);
    step();
    check_eq("t5_grant0", 32'(grant_port),    32'h0);
    check_eq("t5_busy0",  32'(busy),          32'h1);
    check_eq("t5_bubble", 32'(m_axis_tvalid), 32'h0);
    step();
    check_eq("t5_d0",    m_axis_tdata,        32'h1000);
    check_eq("t5_l0",    32'(m_axis_tlast),   32'h1);
    check_eq("t5_v0",    32'(m_axis_tvalid),  32'h1);
    step();

    // FIFO 1 mid-packet while FIFO 0 and 2 request.
    src_send(1, 1, 3);
    step();
    check_eq("t3_grant1", 32'(grant_port), 32'h1);
    src_send(0, 1, 1);
    src_send(2, 1, 1);
    #1;
    check_eq("t3_rdy_a", 32'(s_axis_tready), 32'h2);
    step();
    check_eq("t3_rdy_b", 32'(s_axis_tready), 32'h2);
    check_eq("t3_d0",    m_axis_tdata,       32'h2000);
    step();
    check_eq("t3_rdy_c", 32'(s_axis_tready), 32'h2);
    check_eq("t3_d1",    m_axis_tdata,       32'h2001);
    step();
    check_eq("t3_d2",    m_axis_tdata,       32'h2002);
    check_eq("t3_l2",    32'(m_axis_tlast),  32'h1);
    check_eq("t3_rdy_d", 32'(s_axis_tready), 32'h0);
    step();
    check_eq("t3_grant2", 32'(grant_port),   32'h2);
    step();
    check_eq("t3_dB0",   m_axis_tdata,       32'h00B0);
    step();
    check_eq("t3_grant0", 32'(grant_port),   32'h0);
    step();
    check_eq("t3_d10",   m_axis_tdata,       32'h1010);
    step();

    // Backpressure for 5 cycles mid-packet from FIFO 3.
    src_send(3, 1, 4);
    step();
    check_eq("t4_grant3", 32'(grant_port),   32'h3);
    step();
    check_eq("t4_d0",    m_axis_tdata,       32'h3010);
    m_axis_tready = 1'b0;
    #1;
    check_eq("t4_rdy_bp", 32'(s_axis_tready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t4_hold_v",   32'(m_axis_tvalid), 32'h1);
      check_eq("t4_hold_d",   m_axis_tdata,       32'h3010);
      check_eq("t4_hold_rdy", 32'(s_axis_tready), 32'h0);
    end
    m_axis_tready = 1'b1;
    #1;
    check_eq("t4_rdy_rel", 32'(s_axis_tready), 32'h8);
    step();
    check_eq("t4_d1",    m_axis_tdata,       32'h3011);
    step();
    check_eq("t4_d2",    m_axis_tdata,       32'h3012);
    step();
    check_eq("t4_d3",    m_axis_tdata,       32'h3013);
    check_eq("t4_l3",    32'(m_axis_tlast),  32'h1);
    step();
    check_eq("t4_drain", 32'(m_axis_tvalid), 32'h0);

    // All four FIFOs continuously offer two 2-beat packets each.
    for (int p = 0; p < PORT_NUM; p++) src_send(p, 2, 2);
    for (int j = 0; j < 8; j++) begin
      step();
      check_eq("t2_grant",  32'(grant_port),    32'(t2_grant[j]));
      check_eq("t2_bubble", 32'(m_axis_tvalid), 32'h0);
      step();
      check_eq("t2_b0",     m_axis_tdata,       t2_data[2*j]);
      check_eq("t2_b0_last", 32'(m_axis_tlast), 32'h0);
      step();
      check_eq("t2_b1",     m_axis_tdata,       t2_data[2*j+1]);
      check_eq("t2_b1_last", 32'(m_axis_tlast), 32'h1);
      check_eq("t2_b1_keep", 32'(m_axis_tkeep), 32'h7);
    end
    step();
    check_eq("t2_end_v",    32'(m_axis_tvalid), 32'h0);
    check_eq("t2_end_busy", 32'(busy),          32'h0);

    // Reset during beat 2 of a 4-beat packet from FIFO 0.
    src_send(0, 1, 4);
    step();
    check_eq("t6_grant0", 32'(grant_port), 32'h0);
    step();
    check_eq("t6_d0", m_axis_tdata, 32'h1040);
    step();
    check_eq("t6_d1", m_axis_tdata, 32'h1041);
    glb_areset_n = 1'b0;
    #1;
    check_zero("t6_rst");
    src_send(0, 0, 1);
    step();
    step();
    check_zero("t6_rst_hold");
    glb_areset_n = 1'b1;
    src_send(0, 1, 2);
    step();
    check_eq("t6_regrant", 32'(grant_port), 32'h0);
    check_eq("t6_busy",    32'(busy),       32'h1);
    step();
    check_eq("t6_n0",   m_axis_tdata,       32'h1040);
    check_eq("t6_n0_v", 32'(m_axis_tvalid), 32'h1);
    step();
    check_eq("t6_n1",   m_axis_tdata,       32'h1041);
    check_eq("t6_n1_l", 32'(m_axis_tlast),  32'h1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
